// File: rtl/sccb_pkg.sv
// Shared SCCB target definitions: FSM encoding, device IDs and bit-slot constants.
package sccb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ID     = 3'd1,
    ST_SUB    = 3'd2,
    ST_WDATA  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_IGNORE = 3'd5
  } sccb_state_e;

  localparam logic [7:0] SCCB_ID_WRITE  = 8'h42;
  localparam logic [7:0] SCCB_ID_READ   = 8'h43;

  // Bit slots per byte (8 data + ack/NA); the counter holds slots whose SCL rise has been seen.
  localparam logic [3:0] SCCB_BIT_COUNT = 4'd9;
  localparam logic [3:0] SCCB_LSB_IDX   = 4'd7;
  localparam logic [3:0] SCCB_ACK_IDX   = 4'd8;

  function automatic logic sccb_in_byte_phase(input sccb_state_e s);
    return (s == ST_ID) || (s == ST_SUB) || (s == ST_WDATA) || (s == ST_RDATA);
  endfunction

endpackage

// File: rtl/sccb_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one SCCB line.
// The filtered level moves after FilterDepth consecutive differing samples; rise/fall pulse with the new level.
module sccb_line_filter #(
  parameter int unsigned FilterDepth = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (FilterDepth > 1) ? $clog2(FilterDepth) : 1;

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    sync_d  = {sync_q[0], i_line};
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(FilterDepth - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  // Idle SCCB lines are pulled high, so reset to the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: rtl/sccb_responder.sv
// SCCB camera-side target: decodes ID/sub-address/data writes into a register strobe and serves reads.
// SIO_D is open drain; acks and read data change only on filtered SCL falls.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0]  DeviceId    = SCCB_ID_WRITE,
  parameter int unsigned FilterDepth = 3,
  parameter bit          DriveAck    = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_sio_c,
  inout  wire        io_sio_d,
  output logic [7:0] o_addr,
  output logic [7:0] o_data,
  output logic       o_wr_valid,
  output logic [7:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
  output logic       o_busy,
  output logic       o_err
);

  localparam logic [7:0] ReadId = DeviceId | 8'h01;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  sccb_line_filter #(.FilterDepth(FilterDepth)) u_scl_filter (
    .clk    (CLK),
    .rst    (RST),
    .i_line (i_sio_c),
    .o_level(scl_lvl),
    .o_rise (scl_rise),
    .o_fall (scl_fall)
  );

  sccb_line_filter #(.FilterDepth(FilterDepth)) u_sda_filter (
    .clk    (CLK),
    .rst    (RST),
    .i_line (io_sio_d),
    .o_level(sda_lvl),
    .o_rise (sda_rise),
    .o_fall (sda_fall)
  );

  sccb_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        sda_oe_q, sda_oe_d;
  logic        ack_q, ack_d;
  logic [7:0]  rd_addr_q, rd_addr_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        wr_valid_q, wr_valid_d;
  logic        err_q, err_d;

  logic       scl_edge;
  logic       start_det;
  logic       stop_det;
  logic [7:0] rx_byte;

  // An SDA edge coinciding with an SCL edge is never treated as START/STOP.
  assign scl_edge  = scl_rise | scl_fall;
  assign start_det = sda_fall & scl_lvl & ~scl_edge;
  assign stop_det  = sda_rise & scl_lvl & ~scl_edge;
  assign rx_byte   = {shift_q[6:0], sda_lvl};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    sda_oe_d   = sda_oe_q;
    ack_d      = ack_q;
    rd_addr_d  = rd_addr_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_valid_d = 1'b0;
    err_d      = 1'b0;

    if (state_q == ST_IDLE) begin
      bit_cnt_d = '0;
      ack_d     = 1'b0;
      sda_oe_d  = 1'b0;
      if (start_det) begin
        state_d = ST_ID;
      end
    end else if (start_det) begin
      state_d   = ST_ID;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      ack_d     = 1'b0;
    end else if (stop_det) begin
      // The STOP itself is preceded by one SCL rise, so a count of 1 is still a byte boundary.
      if (sccb_in_byte_phase(state_q) && (bit_cnt_q > 4'd1)) begin
        err_d = 1'b1;
      end
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      ack_d     = 1'b0;
    end else if (scl_rise) begin
      if (bit_cnt_q < SCCB_BIT_COUNT) begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
      if ((bit_cnt_q < SCCB_ACK_IDX) && (state_q != ST_RDATA)) begin
        shift_d = rx_byte;
      end
      if (bit_cnt_q == SCCB_LSB_IDX) begin
        case (state_q)
          ST_ID:    ack_d = (rx_byte == DeviceId) || (rx_byte == ReadId);
          ST_SUB: begin
            ack_d     = 1'b1;
            rd_addr_d = rx_byte;
          end
          ST_WDATA: begin
            ack_d      = 1'b1;
            wr_valid_d = 1'b1;
            addr_d     = rd_addr_q;
            data_d     = rx_byte;
          end
          default:  ack_d = 1'b0;
        endcase
      end
    end else if (scl_fall) begin
      if (bit_cnt_q == SCCB_ACK_IDX) begin
        sda_oe_d = (state_q != ST_RDATA) && ack_q && DriveAck;
      end else if (bit_cnt_q == SCCB_BIT_COUNT) begin
        bit_cnt_d = '0;
        sda_oe_d  = 1'b0;
        ack_d     = 1'b0;
        case (state_q)
          ST_ID: begin
            if (shift_q == DeviceId) begin
              state_d = ST_SUB;
            end else if (shift_q == ReadId) begin
              state_d  = ST_RDATA;
              shift_d  = i_rd_data;
              sda_oe_d = ~i_rd_data[7];
            end else begin
              state_d = ST_IGNORE;
            end
          end
          ST_SUB:  state_d = ST_WDATA;
          default: state_d = ST_IGNORE;
        endcase
      end else if ((state_q == ST_RDATA) && (bit_cnt_q != 4'd0)) begin
        shift_d  = {shift_q[6:0], 1'b0};
        sda_oe_d = ~shift_q[6];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      sda_oe_q   <= 1'b0;
      ack_q      <= 1'b0;
      rd_addr_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sda_oe_q   <= sda_oe_d;
      ack_q      <= ack_d;
      rd_addr_q  <= rd_addr_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_valid_q <= wr_valid_d;
      err_q      <= err_d;
    end
  end

  assign io_sio_d   = sda_oe_q ? 1'b0 : 1'bz;
  assign o_addr     = addr_q;
  assign o_data     = data_q;
  assign o_wr_valid = wr_valid_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_busy     = (state_q != ST_IDLE);
  assign o_err      = err_q;

endmodule
